mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported unified memory between the multi-cycle core (memory requests raised in its
//  fetch/load/store states) and an external loader/debug port. Latches one request at a time, drives the
//  memory for one cycle, times the read latency and returns a one-cycle ack plus registered read data.
//  The core treats a missing ack as a stall and holds its FSM state.
// PARAMETERS
//  ADDR_W   16  address width, both requesters and memory
//  DATA_W   16  data width
//  MEM_LAT  2   memory read latency in cycles (>=1): mem_rdata is valid MEM_LAT cycles after the mem_en cycle
// PORTS
//  CLK        in   1       clock, all state on rising edge
//  Reset_n    in   1       asynchronous, active-low reset
//  core_req   in   1       core request; held until core_ack
//  core_we    in   1       1 = write, 0 = read
//  core_addr  in   ADDR_W  core address
//  core_wdata in   DATA_W  core write data
//  core_ack   out  1       one-cycle completion pulse to core
//  core_rdata out  DATA_W  read data; valid with core_ack, held until the next core read ack
//  ext_req / ext_we / ext_addr / ext_wdata / ext_ack / ext_rdata   same as core_*, for the loader port
//  mem_en     out  1       memory access strobe, exactly one cycle per transaction
//  mem_we     out  1       memory write enable (qualified by mem_en)
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data
//  owner      out  1       0 = core, 1 = ext; owner of the current or most recent transaction
// BEHAVIOUR
//  Reset (Reset_n low, any time): state IDLE; all acks, mem_en, mem_we = 0; mem_addr, mem_wdata,
//   core_rdata, ext_rdata = 0; owner = 1; lat counter = 0. Reset during WAIT abandons the read, no ack.
//  FSM: IDLE -> ISSUE -> (read) WAIT -> ACK -> IDLE;  (write) ISSUE -> ACK -> IDLE.
//  IDLE: if any req, pick winner, latch we/addr/wdata into holding regs, set owner, go ISSUE.
//   No req: stay IDLE, outputs quiet.
//  ISSUE (cycle c): mem_en=1, mem_we=latched we, addr/wdata from holding regs. Reads load the counter with
//   MEM_LAT and enter WAIT; writes enter ACK.
//  WAIT: counter decrements each cycle. mem_rdata is sampled at the end of cycle c+MEM_LAT into the
//   owner's rdata reg, then ACK. The other requester's rdata is untouched.
//  ACK: owner's ack=1 for exactly one cycle, then IDLE.
//  Latency, req first seen in IDLE at cycle t: write ack at t+2; read ack at t+2+MEM_LAT.
//  Requester inputs are ignored after latching; changes mid-transaction have no effect.
//  Requesters drop or renew req in the cycle after ack. A req high in the IDLE cycle after ACK is a
//   new request.
//  Never more than one transaction in flight; no back-to-back mem_en (minimum one idle cycle between).
//  Arbitration, simultaneous requests: fixed priority, core wins. A lone requester is always granted.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin. On simultaneous req, grant the requester != owner, the last
//   served. Reset owner=1, so the core wins first contention; alternation is strict under sustained contention.
//  MEM_ARB_RR_EN undefined: fixed priority as above. The ext port can starve under continuous core traffic.
// STRUCTURE
//  Package mem_arb_pkg: state encoding (IDLE, ISSUE, WAIT, ACK), owner constants (OWN_CORE=0,
//   OWN_EXT=1), default widths, and a MEM_LAT counter width of $clog2(MEM_LAT+1).
//  Sub-module mem_arb_pick: combinational winner selection (core_req, ext_req, last owner -> grant,
//   valid); holds the only MEM_ARB_RR_EN-dependent logic. FSM, holding regs and counter stay in the top.
// TESTING
//  1 Core read, addr 0x0010, mem holds 0xBEEF, MEM_LAT=2 -> single mem_en with we=0 at t+1;
//    core_ack at t+4 with core_rdata=0xBEEF; ext_ack never.
//  2 Ext write, addr 0x0100, data 0x1234, then core read of 0x0100 -> mem_we pulse at t+1, ext_ack at t+2;
//    the later core read returns 0x1234.
//  3 Both req same cycle, three times each, no MEM_ARB_RR_EN -> core served first every time.
//    With MEM_ARB_RR_EN -> grant order core, ext, core, ext...
//  4 Core read of 0x0020 granted, then core_addr changed to 0x0030 during WAIT -> mem_addr stays 0x0020;
//    rdata comes from 0x0020.
//  5 Reset_n low one cycle mid-WAIT -> no ack, all outputs 0, owner=1. A new core read after reset
//    completes normally.
//  6 MEM_LAT=1 and MEM_LAT=4 builds, back-to-back core reads -> ack at t+3 and t+6 respectively;
//    mem_en never asserted in consecutive cycles.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the core/loader memory port arbiter: FSM encoding, owner IDs,
// default widths and the read-latency counter width helper.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W  = 16;
    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_MEM_LAT = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_EXT  = 1'b1;

    // Counter must hold the value MEM_LAT itself.
    function automatic int unsigned lat_cnt_w(input int unsigned lat);
        return $clog2(lat + 1);
    endfunction

    localparam int unsigned DEF_LAT_W = lat_cnt_w(DEF_MEM_LAT);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both requester ports, the memory port and the owner flag.
// slave = arbiter view, master = requesters plus memory view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = mem_arb_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = mem_arb_pkg::DEF_DATA_W
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_ack;
    logic [DATA_W-1:0] core_rdata;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_ack;
    logic [DATA_W-1:0] ext_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              owner;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  mem_rdata,
        output core_ack, core_rdata, ext_ack, ext_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, owner
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output mem_rdata,
        input  core_ack, core_rdata, ext_ack, ext_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, owner
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection. Fixed priority (core wins) by default;
// MEM_ARB_RR_EN switches contention to alternate away from the last owner.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic core_req_i,
    input  logic ext_req_i,
    input  logic last_owner_i,
    output logic grant_c_o,
    output logic valid_c_o
);

    assign valid_c_o = core_req_i | ext_req_i;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant_c_o = OWN_CORE;
        if (core_req_i && ext_req_i) begin
            grant_c_o = ~last_owner_i;
        end else if (ext_req_i) begin
            grant_c_o = OWN_EXT;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;

    always_comb begin
        grant_c_o = core_req_i ? OWN_CORE : OWN_EXT;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between the core and the loader/debug port: one transaction
// in flight, read latency timed by a counter, one-cycle ack. Build option: MEM_ARB_RR_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
    input  logic              CLK,
    input  logic              Reset_n,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned LAT_W = lat_cnt_w(MEM_LAT);

    logic [1:0]        state_q,      state_d;
    logic              hold_we_q,    hold_we_d;
    logic              owner_q,      owner_d;
    logic [LAT_W-1:0]  cnt_q,        cnt_d;
    logic              mem_en_q,     mem_en_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic              core_ack_q,   core_ack_d;
    logic              ext_ack_q,    ext_ack_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] ext_rdata_q,  ext_rdata_d;

    logic grant_c;
    logic valid_c;

    mem_arb_pick u_pick (
        .core_req_i   (bus.core_req),
        .ext_req_i    (bus.ext_req),
        .last_owner_i (owner_q),
        .grant_c_o    (grant_c),
        .valid_c_o    (valid_c)
    );

    // Next state; the memory-side registers double as the request holding registers.
    always_comb begin
        state_d      = state_q;
        hold_we_d    = hold_we_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_ack_d   = 1'b0;
        ext_ack_d    = 1'b0;
        core_rdata_d = core_rdata_q;
        ext_rdata_d  = ext_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_c) begin
                    owner_d  = grant_c;
                    mem_en_d = 1'b1;
                    state_d  = ST_ISSUE;
                    if (grant_c == OWN_EXT) begin
                        hold_we_d   = bus.ext_we;
                        mem_we_d    = bus.ext_we;
                        mem_addr_d  = bus.ext_addr;
                        mem_wdata_d = bus.ext_wdata;
                    end else begin
                        hold_we_d   = bus.core_we;
                        mem_we_d    = bus.core_we;
                        mem_addr_d  = bus.core_addr;
                        mem_wdata_d = bus.core_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                if (hold_we_q) begin
                    state_d    = ST_ACK;
                    core_ack_d = (owner_q == OWN_CORE);
                    ext_ack_d  = (owner_q == OWN_EXT);
                end else begin
                    cnt_d   = LAT_W'(MEM_LAT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - LAT_W'(1);
                // Last wait cycle is the one where mem_rdata is valid.
                if (cnt_q == LAT_W'(1)) begin
                    state_d = ST_ACK;
                    if (owner_q == OWN_EXT) begin
                        ext_rdata_d = bus.mem_rdata;
                        ext_ack_d   = 1'b1;
                    end else begin
                        core_rdata_d = bus.mem_rdata;
                        core_ack_d   = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            hold_we_q    <= 1'b0;
            owner_q      <= OWN_EXT;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_ack_q   <= 1'b0;
            ext_ack_q    <= 1'b0;
            core_rdata_q <= '0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_we_q    <= hold_we_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_ack_q   <= core_ack_d;
            ext_ack_q    <= ext_ack_d;
            core_rdata_q <= core_rdata_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign bus.core_ack   = core_ack_q;
    assign bus.core_rdata = core_rdata_q;
    assign bus.ext_ack    = ext_ack_q;
    assign bus.ext_rdata  = ext_rdata_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.owner      = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural MEM_LAT-cycle memory.
// Contention expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    parameter int unsigned MEM_LAT = DEF_MEM_LAT;

    logic CLK;
    logic Reset_n;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Memory model: unwritten locations read a fixed pattern; reads return MEM_LAT cycles after mem_en.
    logic [15:0]    mem [0:65535];
    logic [65535:0] mem_vld = '0;
    logic [15:0]    rd_pipe [MEM_LAT];

    function automatic logic [15:0] init_val(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hBEEF;
            16'h0020: return 16'hAAAA;
            16'h0030: return 16'h5555;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    function automatic logic [15:0] read_mem(input logic [15:0] a);
        return mem_vld[a] ? mem[a] : init_val(a);
    endfunction

    always @(posedge CLK) begin
        if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) begin
            mem[bus.mem_addr]     <= bus.mem_wdata;
            mem_vld[bus.mem_addr] <= 1'b1;
        end
        rd_pipe[0] <= (bus.mem_en === 1'b1 && bus.mem_we === 1'b0) ? read_mem(bus.mem_addr) : 16'hDEAD;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

    // Bus monitor sampled mid-cycle.
    int          en_count     = 0;
    int          last_en_cyc  = -1;
    int          b2b_viol     = 0;
    int          core_ack_cnt = 0;
    int          ext_ack_cnt  = 0;
    int          ack_wide     = 0;
    logic        last_en_we   = 1'b0;
    logic [15:0] last_en_addr = '0;
    logic        prev_en      = 1'b0;
    logic        prev_cack    = 1'b0;
    logic        prev_eack    = 1'b0;

    always @(negedge CLK) begin
        if (bus.mem_en === 1'b1) begin
            en_count     <= en_count + 1;
            last_en_cyc  <= cyc;
            last_en_we   <= bus.mem_we;
            last_en_addr <= bus.mem_addr;
            if (prev_en) b2b_viol <= b2b_viol + 1;
        end
        prev_en <= (bus.mem_en === 1'b1);
        if (bus.core_ack === 1'b1) core_ack_cnt <= core_ack_cnt + 1;
        if (bus.ext_ack === 1'b1)  ext_ack_cnt  <= ext_ack_cnt + 1;
        if ((bus.core_ack === 1'b1 && prev_cack) || (bus.ext_ack === 1'b1 && prev_eack))
            ack_wide <= ack_wide + 1;
        prev_cack <= (bus.core_ack === 1'b1);
        prev_eack <= (bus.ext_ack === 1'b1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_inputs();
        bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.ext_req  = 1'b0; bus.ext_we  = 1'b0; bus.ext_addr  = '0; bus.ext_wdata  = '0;
    endtask

    // Raise one request, wait for its ack (bounded), drop the request. lat = cycles to ack, -1 on timeout.
    task automatic req_txn(input bit is_ext, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, output int lat);
        if (is_ext) begin
            bus.ext_we = we; bus.ext_addr = addr; bus.ext_wdata = wdata; bus.ext_req = 1'b1;
        end else begin
            bus.core_we = we; bus.core_addr = addr; bus.core_wdata = wdata; bus.core_req = 1'b1;
        end
        lat = -1;
        for (int k = 1; k <= 64; k++) begin
            step(1);
            if ((is_ext ? bus.ext_ack : bus.core_ack) === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (is_ext) bus.ext_req = 1'b0;
        else        bus.core_req = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset_n = 1'b0;
        step(3);
        n_checks++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b want 0", bus.mem_en); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
        n_checks++; if (bus.core_ack !== 1'b0) begin n_fail++; $display("FAIL rst_core_ack: got %b want 0", bus.core_ack); end
        n_checks++; if (bus.ext_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ext_ack: got %b want 0", bus.ext_ack); end
        n_checks++; if (bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0000", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_wdata: got %h want 0000", bus.mem_wdata); end
        n_checks++; if (bus.core_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_core_rdata: got %h want 0000", bus.core_rdata); end
        n_checks++; if (bus.ext_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_ext_rdata: got %h want 0000", bus.ext_rdata); end
        n_checks++; if (bus.owner !== 1'b1) begin n_fail++; $display("FAIL rst_owner: got %b want 1", bus.owner); end
        Reset_n = 1'b1;
        step(3);
        n_checks++; if (en_count !== 0) begin n_fail++; $display("FAIL idle_quiet: mem_en count %0d want 0", en_count); end
    endtask

    task automatic test_core_read();
        int t0, lat, e0, x0;
        e0 = en_count; x0 = ext_ack_cnt; t0 = cyc;
        req_txn(1'b0, 1'b0, 16'h0010, 16'h0000, lat);
        n_checks++; if (lat !== 2 + MEM_LAT) begin n_fail++; $display("FAIL rd_latency: got %0d want %0d", lat, 2 + MEM_LAT); end
        n_checks++; if (bus.core_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %h want beef", bus.core_rdata); end
        n_checks++; if (en_count - e0 !== 1) begin n_fail++; $display("FAIL rd_en_count: got %0d want 1", en_count - e0); end
        n_checks++; if (last_en_cyc !== t0 + 1) begin n_fail++; $display("FAIL rd_en_cycle: got %0d want %0d", last_en_cyc, t0 + 1); end
        n_checks++; if (last_en_we !== 1'b0) begin n_fail++; $display("FAIL rd_en_we: got %b want 0", last_en_we); end
        n_checks++; if (last_en_addr !== 16'h0010) begin n_fail++; $display("FAIL rd_en_addr: got %h want 0010", last_en_addr); end
        n_checks++; if (ext_ack_cnt !== x0) begin n_fail++; $display("FAIL rd_no_ext_ack: got %0d want %0d", ext_ack_cnt, x0); end
        n_checks++; if (bus.owner !== OWN_CORE) begin n_fail++; $display("FAIL rd_owner: got %b want 0", bus.owner); end
        step(1);
    endtask

    task automatic test_ext_write();
        int t0, lat;
        t0 = cyc;
        req_txn(1'b1, 1'b1, 16'h0100, 16'h1234, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d want 2", lat); end
        n_checks++; if (last_en_cyc !== t0 + 1) begin n_fail++; $display("FAIL wr_en_cycle: got %0d want %0d", last_en_cyc, t0 + 1); end
        n_checks++; if (last_en_we !== 1'b1) begin n_fail++; $display("FAIL wr_en_we: got %b want 1", last_en_we); end
        n_checks++; if (last_en_addr !== 16'h0100) begin n_fail++; $display("FAIL wr_en_addr: got %h want 0100", last_en_addr); end
        n_checks++; if (read_mem(16'h0100) !== 16'h1234) begin n_fail++; $display("FAIL wr_mem: got %h want 1234", read_mem(16'h0100)); end
        n_checks++; if (bus.owner !== OWN_EXT) begin n_fail++; $display("FAIL wr_owner: got %b want 1", bus.owner); end
        step(1);
        req_txn(1'b0, 1'b0, 16'h0100, 16'h0000, lat);
        n_checks++; if (lat !== 2 + MEM_LAT) begin n_fail++; $display("FAIL wr_rd_latency: got %0d want %0d", lat, 2 + MEM_LAT); end
        n_checks++; if (bus.core_rdata !== 16'h1234) begin n_fail++; $display("FAIL wr_rd_data: got %h want 1234", bus.core_rdata); end
        n_checks++; if (bus.ext_rdata !== 16'h0000) begin n_fail++; $display("FAIL ext_rdata_untouched: got %h want 0000", bus.ext_rdata); end
        step(1);
    endtask

    task automatic test_addr_hold();
        int lat;
        bus.core_we = 1'b0; bus.core_addr = 16'h0020; bus.core_wdata = 16'h0000; bus.core_req = 1'b1;
        step(1);
        n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0020) begin
            n_fail++; $display("FAIL hold_issue: got en=%b addr=%h want en=1 addr=0020", bus.mem_en, bus.mem_addr);
        end
        step(1);
        bus.core_addr = 16'h0030; bus.core_wdata = 16'hFFFF; bus.core_we = 1'b1;
        #1;
        n_checks++; if (bus.mem_addr !== 16'h0020) begin n_fail++; $display("FAIL hold_addr: got %h want 0020", bus.mem_addr); end
        lat = -1;
        for (int k = 3; k <= 64; k++) begin
            step(1);
            if (bus.core_ack === 1'b1) begin
                lat = k;
                break;
            end
        end
        bus.core_req = 1'b0; bus.core_we = 1'b0;
        n_checks++; if (lat !== 2 + MEM_LAT) begin n_fail++; $display("FAIL hold_latency: got %0d want %0d", lat, 2 + MEM_LAT); end
        n_checks++; if (bus.core_rdata !== 16'hAAAA) begin n_fail++; $display("FAIL hold_data: got %h want aaaa", bus.core_rdata); end
        n_checks++; if (read_mem(16'h0030) !== 16'h5555) begin n_fail++; $display("FAIL hold_no_write: got %h want 5555", read_mem(16'h0030)); end
        step(1);
    endtask

    task automatic test_reset_mid_wait();
        int a0, t0, lat;
        a0 = core_ack_cnt;
        bus.core_we = 1'b0; bus.core_addr = 16'h0040; bus.core_req = 1'b1;
        step(2);
        bus.core_req = 1'b0;
        Reset_n = 1'b0;
        #1;
        n_checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_mem: got en=%b we=%b want 0 0", bus.mem_en, bus.mem_we);
        end
        n_checks++; if (bus.core_rdata !== 16'h0000 || bus.mem_addr !== 16'h0000) begin
            n_fail++; $display("FAIL mid_rst_data: got rdata=%h addr=%h want 0000 0000", bus.core_rdata, bus.mem_addr);
        end
        n_checks++; if (bus.owner !== 1'b1) begin n_fail++; $display("FAIL mid_rst_owner: got %b want 1", bus.owner); end
        step(1);
        Reset_n = 1'b1;
        step(MEM_LAT + 4);
        n_checks++; if (core_ack_cnt !== a0) begin n_fail++; $display("FAIL mid_rst_no_ack: got %0d acks want %0d", core_ack_cnt, a0); end
        t0 = cyc;
        req_txn(1'b0, 1'b0, 16'h0010, 16'h0000, lat);
        n_checks++; if (lat !== 2 + MEM_LAT) begin n_fail++; $display("FAIL post_rst_latency: got %0d want %0d", lat, 2 + MEM_LAT); end
        n_checks++; if (bus.core_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL post_rst_data: got %h want beef", bus.core_rdata); end
        n_checks++; if (last_en_cyc !== t0 + 1) begin n_fail++; $display("FAIL post_rst_en_cycle: got %0d want %0d", last_en_cyc, t0 + 1); end
        step(1);
    endtask

    task automatic test_contention();
        int          nc, ne, n;
        logic [5:0]  order, exp_order;
        logic [15:0] a;
`ifdef MEM_ARB_RR_EN
        exp_order = 6'b101010;
`else
        exp_order = 6'b111000;
`endif
        Reset_n = 1'b0;
        step(1);
        Reset_n = 1'b1;
        step(1);
        nc = 0; ne = 0; n = 0; order = '0;
        bus.core_we = 1'b0; bus.core_addr = 16'h0050;
        bus.ext_we  = 1'b0; bus.ext_addr  = 16'h0060;
        bus.core_req = 1'b1; bus.ext_req = 1'b1;
        for (int k = 0; k < 200 && n < 6; k++) begin
            step(1);
            if (bus.core_ack === 1'b1) begin
                a = 16'h0050 + 16'(nc);
                n_checks++; if (bus.core_rdata !== init_val(a)) begin
                    n_fail++; $display("FAIL cont_core_data: got %h want %h", bus.core_rdata, init_val(a));
                end
                order[n] = 1'b0; n++; nc++;
                if (nc == 3) bus.core_req = 1'b0;
                else         bus.core_addr = 16'h0050 + 16'(nc);
            end
            if (bus.ext_ack === 1'b1) begin
                a = 16'h0060 + 16'(ne);
                n_checks++; if (bus.ext_rdata !== init_val(a)) begin
                    n_fail++; $display("FAIL cont_ext_data: got %h want %h", bus.ext_rdata, init_val(a));
                end
                order[n] = 1'b1; n++; ne++;
                if (ne == 3) bus.ext_req = 1'b0;
                else         bus.ext_addr = 16'h0060 + 16'(ne);
            end
        end
        bus.core_req = 1'b0; bus.ext_req = 1'b0;
        n_checks++; if (n !== 6) begin n_fail++; $display("FAIL cont_count: got %0d grants want 6", n); end
        n_checks++; if (order !== exp_order) begin n_fail++; $display("FAIL cont_order: got %b want %b (bit0 first, 1=ext)", order, exp_order); end
        step(1);
    endtask

    task automatic test_back_to_back();
        int          t0, n, e0, v0;
        int          exp_cyc;
        logic [15:0] a;
        e0 = en_count; v0 = b2b_viol; n = 0;
        bus.core_we = 1'b0; bus.core_addr = 16'h0070; bus.core_req = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 200 && n < 3; k++) begin
            step(1);
            if (bus.core_ack === 1'b1) begin
                exp_cyc = t0 + 2 + int'(MEM_LAT) + n * (3 + int'(MEM_LAT));
                a = 16'h0070 + 16'(n);
                n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL b2b_ack_cycle%0d: got %0d want %0d", n, cyc, exp_cyc); end
                n_checks++; if (bus.core_rdata !== init_val(a)) begin
                    n_fail++; $display("FAIL b2b_data%0d: got %h want %h", n, bus.core_rdata, init_val(a));
                end
                n++;
                if (n == 3) bus.core_req = 1'b0;
                else        bus.core_addr = 16'h0070 + 16'(n);
            end
        end
        bus.core_req = 1'b0;
        step(1);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d acks want 3", n); end
        n_checks++; if (en_count - e0 !== 3) begin n_fail++; $display("FAIL b2b_en_count: got %0d want 3", en_count - e0); end
        n_checks++; if (b2b_viol !== v0 || b2b_viol !== 0) begin
            n_fail++; $display("FAIL b2b_mem_en_gap: got %0d consecutive mem_en want 0", b2b_viol);
        end
        n_checks++; if (ack_wide !== 0) begin n_fail++; $display("FAIL ack_width: got %0d multi-cycle acks want 0", ack_wide); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_core_read();
        test_ext_write();
        test_addr_hold();
        test_reset_mid_wait();
        test_contention();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
